// File: rtl/accum_readout_seq_pkg.sv
// Shared definitions for the accumulator readout sequencer and the accumulator top.
// Mode and state encodings plus the default source slot assignment.
package accum_readout_defs;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } state_t;

    // Source slots as wired by the accumulator datapath
    localparam int unsigned REG2_LSB      = 32'd0;
    localparam int unsigned REG2_MSB      = 32'd1;
    localparam int unsigned COUNTER_VALUE = 32'd2;
    localparam int unsigned COUNTER_CARRY = 32'd3;

endpackage

// File: rtl/accum_readout_seq_pick.sv
// Priority encoder: index of the lowest set bit of a mask plus an any-set flag.
module lowest_set_pick #(
    parameter int NUM_SRC = 4,
    parameter int SEL_W   = 2
) (
    input  logic [NUM_SRC-1:0] mask,
    output logic [SEL_W-1:0]   idx,
    output logic               any
);

    logic found_s;

    // Scan upward and latch the first set bit; later bits are ignored
    always_comb begin
        idx     = {SEL_W{1'b0}};
        found_s = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (mask[i] && !found_s) begin
                idx     = SEL_W'(i);
                found_s = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
        any = found_s;
    end

endmodule

// File: rtl/accum_readout_seq.sv
// Registered source selector: direct select in IDLE, or a masked ascending scan
// emitted as valid/ready beats with a done pulse at the end.
module accum_readout_seq
    import accum_readout_defs::*;
#(
    parameter int  WIDTH   = 8,
    parameter int  NUM_SRC = 4,
    localparam int SEL_W   = $clog2(NUM_SRC)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_SRC*WIDTH-1:0] src_data,
    input  logic                     mode,
    input  logic [SEL_W-1:0]         sel,
    input  logic                     start,
    input  logic [NUM_SRC-1:0]       src_mask,
    output logic [WIDTH-1:0]         out_data,
    output logic [SEL_W-1:0]         out_sel,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     busy,
    output logic                     done
);

    localparam logic [NUM_SRC-1:0] BIT0 = NUM_SRC'(1'b1);

    state_t               state_r, state_s;
    logic [NUM_SRC-1:0]   pending_r, pending_s;
    logic [NUM_SRC-1:0]   pick_in_s, pick_rest_s;
    logic [SEL_W-1:0]     pick_idx_s;
    logic                 pick_any_s;
    logic [WIDTH-1:0]     out_data_s;
    logic [SEL_W-1:0]     out_sel_s;
    logic                 out_valid_s, busy_s, done_s;

    function automatic logic [WIDTH-1:0] src_word(input logic [NUM_SRC*WIDTH-1:0] srcs,
                                                  input logic [SEL_W-1:0] idx);
        return srcs[idx*WIDTH +: WIDTH];
    endfunction

    // One encoder serves both the first pick (from the request mask) and every next pick
    assign pick_in_s   = (state_r == ST_IDLE) ? src_mask : pending_r;
    assign pick_rest_s = pick_in_s & ~(BIT0 << pick_idx_s);

    lowest_set_pick #(.NUM_SRC(NUM_SRC), .SEL_W(SEL_W)) u_pick (
        .mask (pick_in_s),
        .idx  (pick_idx_s),
        .any  (pick_any_s)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (mode == MODE_SCAN && start && pick_any_s) begin
                    state_s = ST_SCAN;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SCAN: begin
                if (out_valid && out_ready && !pick_any_s) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_SCAN;
                end
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // Next values of the registered outputs and the pending mask
    always_comb begin
        out_data_s  = out_data;
        out_sel_s   = out_sel;
        out_valid_s = out_valid;
        busy_s      = busy;
        done_s      = 1'b0;
        pending_s   = pending_r;
        case (state_r)
            ST_IDLE: begin
                if (mode == MODE_DIRECT) begin
                    out_sel_s = sel;
                    if (32'(sel) < 32'(NUM_SRC)) begin
                        out_data_s = src_word(src_data, sel);
                    end else begin
                        out_data_s = {WIDTH{1'b0}};
                    end
                end else if (start && pick_any_s) begin
                    out_data_s  = src_word(src_data, pick_idx_s);
                    out_sel_s   = pick_idx_s;
                    out_valid_s = 1'b1;
                    busy_s      = 1'b1;
                    pending_s   = pick_rest_s;
                end else if (start) begin
                    done_s = 1'b1;
                end else begin
                    done_s = 1'b0;
                end
            end
            ST_SCAN: begin
                if (out_valid && out_ready && pick_any_s) begin
                    out_data_s = src_word(src_data, pick_idx_s);
                    out_sel_s  = pick_idx_s;
                    pending_s  = pick_rest_s;
                end else if (out_valid && out_ready) begin
                    out_valid_s = 1'b0;
                    busy_s      = 1'b0;
                    done_s      = 1'b1;
                    pending_s   = {NUM_SRC{1'b0}};
                end else begin
                    pending_s = pending_r;
                end
            end
            default: begin
                out_valid_s = 1'b0;
                busy_s      = 1'b0;
                pending_s   = {NUM_SRC{1'b0}};
            end
        endcase
    end

    // Output and pending-mask registers
    always_ff @(posedge clk) begin
        if (reset) begin
            out_data  <= {WIDTH{1'b0}};
            out_sel   <= {SEL_W{1'b0}};
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pending_r <= {NUM_SRC{1'b0}};
        end else begin
            out_data  <= out_data_s;
            out_sel   <= out_sel_s;
            out_valid <= out_valid_s;
            busy      <= busy_s;
            done      <= done_s;
            pending_r <= pending_s;
        end
    end

endmodule

// File: tb/tb_accum_readout_seq.sv
// Directed bench for accum_readout_seq: expected beats are queued by the stimulus
// and popped by a monitor on every handshake.
module tb_accum_readout_seq;

    typedef struct packed {
        logic [7:0] data;
        logic [1:0] sel;
    } beat_t;

    logic        clk;
    logic        reset;
    logic [31:0] src_data;
    logic        mode;
    logic [1:0]  sel;
    logic        start;
    logic [3:0]  src_mask;
    logic [7:0]  out_data;
    logic [1:0]  out_sel;
    logic        out_valid;
    logic        out_ready;
    logic        busy;
    logic        done;

    int total = 0;
    int bad   = 0;
    int done_cnt  = 0;
    int valid_cnt = 0;
    int mark;
    beat_t exp_q[$];

    logic       stall_prev = 1'b0;
    logic [7:0] stall_data;
    logic [1:0] stall_sel;

    accum_readout_seq #(.WIDTH(8), .NUM_SRC(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .src_data  (src_data),
        .mode      (mode),
        .sel       (sel),
        .start     (start),
        .src_mask  (src_mask),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic push(input logic [7:0] d, input logic [1:0] s);
        beat_t b;
        b.data = d;
        b.sel  = s;
        exp_q.push_back(b);
    endtask

    // Monitor: pop on each handshake, check hold stability across stalls
    always @(negedge clk) begin
        beat_t b;
        if (!reset) begin
            if (done) done_cnt++;
            if (out_valid) valid_cnt++;
            if (stall_prev && out_valid) begin
                chk("hold_data", 32'(out_data), 32'(stall_data));
                chk("hold_sel", 32'(out_sel), 32'(stall_sel));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", 32'(out_valid), 32'd0);
                end else begin
                    b = exp_q.pop_front();
                    chk("beat_data", 32'(out_data), 32'(b.data));
                    chk("beat_sel", 32'(out_sel), 32'(b.sel));
                end
            end
            stall_prev = out_valid && !out_ready;
            stall_data = out_data;
            stall_sel  = out_sel;
        end else begin
            stall_prev = 1'b0;
        end
    end

    initial begin
        reset     = 1'b1;
        src_data  = {8'h04, 8'h03, 8'hB2, 8'hA1};
        mode      = 1'b0;
        sel       = 2'd2;
        start     = 1'b0;
        src_mask  = 4'b0000;
        out_ready = 1'b1;
        step();
        step();
        chk("rst_data", 32'(out_data), 32'h0);
        chk("rst_sel", 32'(out_sel), 32'h0);
        chk("rst_valid", 32'(out_valid), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_done", 32'(done), 32'h0);

        // Direct mode
        reset = 1'b0;
        step();
        chk("dir_sel2_data", 32'(out_data), 32'h03);
        chk("dir_sel2_sel", 32'(out_sel), 32'd2);
        sel = 2'd3;
        step();
        chk("dir_sel3_data", 32'(out_data), 32'h04);
        sel = 2'd0;
        step();
        chk("dir_sel0_data", 32'(out_data), 32'hA1);
        chk("dir_valid", 32'(out_valid), 32'h0);

        // Full scan, ready always high
        done_cnt = 0;
        mode = 1'b1; start = 1'b1; src_mask = 4'b1111;
        push(8'hA1, 2'd0); push(8'hB2, 2'd1); push(8'h03, 2'd2); push(8'h04, 2'd3);
        step();
        start = 1'b0;
        chk("full_first_sel", 32'(out_sel), 32'd0);
        chk("full_busy", 32'(busy), 32'h1);
        step(); step(); step();
        chk("full_last_data", 32'(out_data), 32'h04);
        chk("full_done_early", 32'(done), 32'h0);
        step();
        chk("full_done", 32'(done), 32'h1);
        chk("full_busy_off", 32'(busy), 32'h0);
        chk("full_valid_off", 32'(out_valid), 32'h0);
        step();
        chk("full_done_pulse", 32'(done), 32'h0);
        chk("full_done_cnt", 32'(done_cnt), 32'd1);
        chk("full_q_empty", 32'(exp_q.size()), 32'd0);

        // Sparse scan with backpressure and a source change mid-stall
        done_cnt = 0;
        out_ready = 1'b0; start = 1'b1; src_mask = 4'b1010;
        push(8'hB2, 2'd1); push(8'h04, 2'd3);
        step();
        start = 1'b0;
        src_data[15:8] = 8'hFF;
        chk("sparse_first", 32'(out_data), 32'hB2);
        step();
        chk("sparse_hold1", 32'(out_data), 32'hB2);
        step();
        chk("sparse_hold2", 32'(out_data), 32'hB2);
        chk("sparse_hold_sel", 32'(out_sel), 32'd1);
        out_ready = 1'b1;
        step();
        chk("sparse_second", 32'(out_data), 32'h04);
        step();
        chk("sparse_done", 32'(done), 32'h1);
        step();
        chk("sparse_done_cnt", 32'(done_cnt), 32'd1);
        chk("sparse_q_empty", 32'(exp_q.size()), 32'd0);
        src_data[15:8] = 8'hB2;

        // Empty mask
        done_cnt = 0;
        mark = valid_cnt;
        start = 1'b1; src_mask = 4'b0000;
        step();
        start = 1'b0;
        chk("empty_done", 32'(done), 32'h1);
        chk("empty_busy", 32'(busy), 32'h0);
        step();
        chk("empty_done_pulse", 32'(done), 32'h0);
        chk("empty_no_valid", 32'(valid_cnt - mark), 32'd0);
        chk("empty_done_cnt", 32'(done_cnt), 32'd1);

        // Start and mode changes during a scan are ignored
        done_cnt = 0;
        start = 1'b1; src_mask = 4'b0101;
        push(8'hA1, 2'd0); push(8'h03, 2'd2);
        step();
        mode = 1'b0; src_mask = 4'b1111;
        step();
        start = 1'b0;
        chk("ign_second_sel", 32'(out_sel), 32'd2);
        chk("ign_busy", 32'(busy), 32'h1);
        step();
        chk("ign_done", 32'(done), 32'h1);
        step();
        step();
        chk("ign_done_cnt", 32'(done_cnt), 32'd1);
        chk("ign_q_empty", 32'(exp_q.size()), 32'd0);

        // Reset mid-scan aborts, then a fresh scan restarts at index 0
        done_cnt = 0;
        mode = 1'b1; start = 1'b1; src_mask = 4'b1111;
        push(8'hA1, 2'd0); push(8'hB2, 2'd1); push(8'h03, 2'd2); push(8'h04, 2'd3);
        step();
        start = 1'b0;
        step();
        chk("abort_second", 32'(out_data), 32'hB2);
        reset = 1'b1;
        step();
        chk("abort_valid", 32'(out_valid), 32'h0);
        chk("abort_busy", 32'(busy), 32'h0);
        chk("abort_done", 32'(done), 32'h0);
        chk("abort_q_left", 32'(exp_q.size()), 32'd3);
        exp_q.delete();
        reset = 1'b0;
        step();
        chk("abort_no_done", 32'(done_cnt), 32'd0);
        start = 1'b1;
        push(8'hA1, 2'd0); push(8'hB2, 2'd1); push(8'h03, 2'd2); push(8'h04, 2'd3);
        step();
        start = 1'b0;
        chk("restart_sel", 32'(out_sel), 32'd0);
        step(); step(); step(); step();
        chk("restart_done", 32'(done), 32'h1);
        step();
        chk("restart_q_empty", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
